// File: rtl/fltr_multi_ch.sv
// rtl/fltr_multi_ch.sv - multi-channel run-length trigger filter with fixed-length output pulse
// Optional per-channel event counters are built when FLTR_EVT_CNT_EN is defined.
module fltr_multi_ch #(
  parameter int CH    = 4,
  parameter int N     = 3,
  parameter int PULSE = 2,
  parameter int CW    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CH-1:0]      in,
  input  logic [CH-1:0]      pol,
  input  logic [CH-1:0]      en,
`ifdef FLTR_EVT_CNT_EN
  input  logic               clr_cnt,
  output logic [CH*CW-1:0]   evt_cnt,
`endif
  output logic [CH-1:0]      out,
  output logic [CH-1:0]      busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PULSE = 2'd1;
  localparam logic [1:0] S_SKIP  = 2'd2;

  localparam logic [7:0] L_N    = 8'(N);
  localparam logic [8:0] L_N9   = 9'(N);
  localparam logic [7:0] L_PLD  = 8'(PULSE - 1);

  logic [1:0]    r_state [CH];
  logic [7:0]    r_run   [CH];
  logic [7:0]    r_pcnt  [CH];
  logic [CH-1:0] r_out;
  logic [CH-1:0] r_busy;

  logic [CH-1:0] w_act;
  logic [CH-1:0] w_trig;

  assign w_act = ~(in ^ pol);

  // Trigger fires on the sample that completes the Nth consecutive active run.
  always_comb begin
    w_trig = '0;
    for (int k = 0; k < CH; k++) begin
      w_trig[k] = en[k] && (r_state[k] == S_IDLE) && w_act[k] &&
                  (({1'b0, r_run[k]} + 9'd1) >= L_N9);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < CH; k++) begin
        r_state[k] <= S_IDLE;
        r_run[k]   <= '0;
        r_pcnt[k]  <= '0;
      end
      r_out  <= '0;
      r_busy <= '0;
    end else begin
      for (int k = 0; k < CH; k++) begin
        if (!en[k]) begin
          r_state[k] <= S_IDLE;
          r_run[k]   <= '0;
          r_pcnt[k]  <= '0;
          r_out[k]   <= 1'b0;
          r_busy[k]  <= 1'b0;
        end else begin
          case (r_state[k])
            S_IDLE: begin
              if (w_trig[k]) begin
                r_state[k] <= S_PULSE;
                r_pcnt[k]  <= L_PLD;
                r_run[k]   <= '0;
                r_out[k]   <= 1'b1;
                r_busy[k]  <= 1'b1;
              end else if (w_act[k]) begin
                r_run[k] <= (r_run[k] == L_N) ? r_run[k] : r_run[k] + 8'd1;
              end else begin
                r_run[k] <= '0;
              end
            end
            S_PULSE: begin
              if (r_pcnt[k] == 8'd0) begin
                r_out[k] <= 1'b0;
                if (w_act[k]) begin
                  r_state[k] <= S_SKIP;
                  r_busy[k]  <= 1'b1;
                end else begin
                  r_state[k] <= S_IDLE;
                  r_busy[k]  <= 1'b0;
                end
              end else begin
                r_pcnt[k] <= r_pcnt[k] - 8'd1;
              end
            end
            S_SKIP: begin
              // The releasing inactive sample is consumed here, not counted.
              if (!w_act[k]) begin
                r_state[k] <= S_IDLE;
                r_run[k]   <= '0;
                r_busy[k]  <= 1'b0;
              end
            end
            default: begin
              r_state[k] <= S_IDLE;
              r_run[k]   <= '0;
              r_pcnt[k]  <= '0;
              r_out[k]   <= 1'b0;
              r_busy[k]  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign out  = r_out;
  assign busy = r_busy;

`ifdef FLTR_EVT_CNT_EN
  logic [CW-1:0] r_evt [CH];

  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      for (int k = 0; k < CH; k++) begin
        r_evt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < CH; k++) begin
        if (w_trig[k] && (r_evt[k] != {CW{1'b1}})) begin
          r_evt[k] <= r_evt[k] + 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_evt
    assign evt_cnt[g*CW +: CW] = r_evt[g];
  end
`endif

endmodule

// File: tb/tb_fltr_multi_ch.sv
// tb/tb_fltr_multi_ch.sv - self-checking bench for fltr_multi_ch
// Scoreboard of a behavioural model plus directed per-feature scenarios.
module tb_fltr_multi_ch;

  localparam int CH    = 4;
  localparam int N     = 3;
  localparam int PULSE = 2;
`ifdef FLTR_EVT_CNT_EN
  localparam int CW    = 2;
`else
  localparam int CW    = 8;
`endif
  localparam int CH1   = 2;

  typedef struct packed {
    logic [CH-1:0]    o;
    logic [CH-1:0]    b;
    logic [CH*CW-1:0] e;
  } exp_t;

  logic               clk;
  logic               t_rst;
  logic               t_clr;
  logic [CH-1:0]      t_in, t_pol, t_en;
  logic [CH-1:0]      out, busy;
  logic [CH*CW-1:0]   evt_cnt;
  logic [CH1-1:0]     t_in1;
  logic [CH1-1:0]     out1, busy1;
  logic [CH1*CW-1:0]  evt_cnt1;

  int errors = 0;
  int checks = 0;

  exp_t sb[$];
  exp_t sb_x;

  int m_mode [CH];
  int m_run  [CH];
  int m_left [CH];
  int m_ev   [CH];

  fltr_multi_ch #(.CH(CH), .N(N), .PULSE(PULSE), .CW(CW)) dut (
    .clk(clk), .rst(t_rst), .in(t_in), .pol(t_pol), .en(t_en),
`ifdef FLTR_EVT_CNT_EN
    .clr_cnt(t_clr), .evt_cnt(evt_cnt),
`endif
    .out(out), .busy(busy)
  );

  fltr_multi_ch #(.CH(CH1), .N(1), .PULSE(3), .CW(CW)) dut1 (
    .clk(clk), .rst(t_rst), .in(t_in1), .pol({CH1{1'b1}}), .en({CH1{1'b1}}),
`ifdef FLTR_EVT_CNT_EN
    .clr_cnt(t_clr), .evt_cnt(evt_cnt1),
`endif
    .out(out1), .busy(busy1)
  );

`ifndef FLTR_EVT_CNT_EN
  assign evt_cnt  = '0;
  assign evt_cnt1 = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_x = sb.pop_front();
      checks++;
      if (out !== sb_x.o) begin
        errors++;
        $display("FAIL sb_out t=%0t got %b want %b", $time, out, sb_x.o);
      end
      checks++;
      if (busy !== sb_x.b) begin
        errors++;
        $display("FAIL sb_busy t=%0t got %b want %b", $time, busy, sb_x.b);
      end
`ifdef FLTR_EVT_CNT_EN
      checks++;
      if (evt_cnt !== sb_x.e) begin
        errors++;
        $display("FAIL sb_evt t=%0t got %h want %h", $time, evt_cnt, sb_x.e);
      end
`endif
    end
  end

  // Apply inputs, advance the model, queue what the DUT must show after the edge.
  task automatic drive(input logic [CH-1:0] vin, input logic [CH-1:0] vpol,
                       input logic [CH-1:0] ven, input logic vrst, input logic vclr);
    exp_t x;
    bit   a, trig;
    t_in = vin; t_pol = vpol; t_en = ven; t_rst = vrst; t_clr = vclr;
    for (int k = 0; k < CH; k++) begin
      if (vrst) begin
        m_mode[k] = 0; m_run[k] = 0; m_left[k] = 0; m_ev[k] = 0;
      end else begin
        a = (vin[k] == vpol[k]);
        trig = 0;
        if (!ven[k]) begin
          m_mode[k] = 0; m_run[k] = 0; m_left[k] = 0;
        end else if (m_mode[k] == 0) begin
          if (a) begin
            m_run[k]++;
            if (m_run[k] >= N) begin
              m_mode[k] = 1; m_left[k] = PULSE; m_run[k] = 0; trig = 1;
            end
          end else begin
            m_run[k] = 0;
          end
        end else if (m_mode[k] == 1) begin
          m_left[k]--;
          if (m_left[k] == 0) m_mode[k] = a ? 2 : 0;
        end else begin
          if (!a) m_mode[k] = 0;
        end
        if (vclr) m_ev[k] = 0;
        else if (trig && m_ev[k] < (1 << CW) - 1) m_ev[k]++;
      end
      x.o[k] = (m_mode[k] == 1);
      x.b[k] = (m_mode[k] != 0);
      x.e[k*CW +: CW] = CW'(m_ev[k]);
    end
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    for (int i = 0; i < 4; i++) drive('0, '1, '1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    drive('1, '1, '1, 1'b1, 1'b0);
    drive('1, '1, '1, 1'b1, 1'b0);
    checks++;
    if (out !== '0 || busy !== '0) begin
      errors++;
      $display("FAIL reset_outputs got out=%b busy=%b want 0/0", out, busy);
    end
    checks++;
    if (evt_cnt !== '0 || out1 !== '0) begin
      errors++;
      $display("FAIL reset_evt got evt=%h out1=%b want 0", evt_cnt, out1);
    end
    settle();
  endtask

  task automatic test_basic();
    bit s_in [6] = '{0, 1, 1, 1, 0, 0};
    bit s_out[6] = '{0, 0, 0, 1, 1, 0};
    logic [CH-1:0] v;
    for (int i = 0; i < 6; i++) begin
      v = '0; v[0] = s_in[i];
      drive(v, '1, '1, 1'b0, 1'b0);
      checks++;
      if (out[0] !== s_out[i] || busy[0] !== s_out[i]) begin
        errors++;
        $display("FAIL basic cyc %0d got out=%b busy=%b want %b", i, out[0], busy[0], s_out[i]);
      end
    end
    settle();
  endtask

  task automatic test_hold_skip();
    logic [CH-1:0] v;
    int rises = 0;
    bit prev = 0, busy_ok = 1;
    for (int i = 0; i < 14; i++) begin
      v = '0; v[1] = (i != 10);
      drive(v, '1, '1, 1'b0, 1'b0);
      if (i < 10) begin
        if (out[1] && !prev) rises++;
        if (i >= 2 && busy[1] !== 1'b1) busy_ok = 0;
      end
      if (i == 10) begin
        checks++;
        if (busy[1] !== 1'b0) begin
          errors++;
          $display("FAIL hold_release got busy=%b want 0", busy[1]);
        end
      end
      if (i == 11 || i == 12) begin
        checks++;
        if (out[1] !== 1'b0) begin
          errors++;
          $display("FAIL hold_early_retrig cyc %0d got out=%b want 0", i, out[1]);
        end
      end
      if (i == 13) begin
        checks++;
        if (out[1] !== 1'b1) begin
          errors++;
          $display("FAIL hold_retrig got out=%b want 1", out[1]);
        end
      end
      prev = out[1];
    end
    checks++;
    if (rises != 1) begin
      errors++;
      $display("FAIL hold_pulses got %0d want 1", rises);
    end
    checks++;
    if (!busy_ok) begin
      errors++;
      $display("FAIL hold_busy got low during run want high");
    end
    settle();
  endtask

  task automatic test_polarity();
    bit a_in [5] = '{1, 0, 0, 0, 1};
    bit a_out[5] = '{0, 0, 0, 1, 1};
    bit b_in [6] = '{1, 1, 0, 1, 1, 1};
    bit b_out[6] = '{0, 0, 0, 0, 0, 1};
    logic [CH-1:0] v, p;
    p = '1; p[2] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      v = '0; v[2] = a_in[i];
      drive(v, p, '1, 1'b0, 1'b0);
      checks++;
      if (out[2] !== a_out[i]) begin
        errors++;
        $display("FAIL pol_low cyc %0d got %b want %b", i, out[2], a_out[i]);
      end
    end
    v = '0; v[2] = 1'b1;
    for (int i = 0; i < 4; i++) drive(v, p, '1, 1'b0, 1'b0);
    settle();
    for (int i = 0; i < 6; i++) begin
      v = '0; v[2] = b_in[i];
      drive(v, '1, '1, 1'b0, 1'b0);
      checks++;
      if (out[2] !== b_out[i]) begin
        errors++;
        $display("FAIL pol_high cyc %0d got %b want %b", i, out[2], b_out[i]);
      end
    end
    settle();
  endtask

  task automatic test_abort();
    logic [CH-1:0] v, e;
    v = '0; v[3] = 1'b1;
    e = '1; e[3] = 1'b0;
    for (int i = 0; i < 3; i++) drive(v, '1, '1, 1'b0, 1'b0);
    checks++;
    if (out[3] !== 1'b1) begin
      errors++;
      $display("FAIL en_trig got %b want 1", out[3]);
    end
    drive(v, '1, e, 1'b0, 1'b0);
    checks++;
    if (out[3] !== 1'b0 || busy[3] !== 1'b0) begin
      errors++;
      $display("FAIL en_abort got out=%b busy=%b want 0/0", out[3], busy[3]);
    end
    drive(v, '1, '1, 1'b0, 1'b0);
    checks++;
    if (busy[3] !== 1'b0) begin
      errors++;
      $display("FAIL en_no_skip got busy=%b want 0", busy[3]);
    end
    settle();
    v = '0; v[0] = 1'b1;
    for (int i = 0; i < 3; i++) drive(v, '1, '1, 1'b0, 1'b0);
    drive(v, '1, '1, 1'b1, 1'b0);
    checks++;
    if (out[0] !== 1'b0 || busy[0] !== 1'b0 || evt_cnt !== '0) begin
      errors++;
      $display("FAIL rst_abort got out=%b busy=%b evt=%h want 0/0/0", out[0], busy[0], evt_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      drive(v, '1, '1, 1'b0, 1'b0);
      checks++;
      if (out[0] !== (i == 2)) begin
        errors++;
        $display("FAIL rst_first_sample cyc %0d got %b want %b", i, out[0], (i == 2));
      end
    end
    settle();
  endtask

  task automatic test_evt_cnt();
`ifdef FLTR_EVT_CNT_EN
    logic [CH-1:0] v;
    bit pat[6] = '{1, 1, 1, 0, 0, 0};
    drive('0, '1, '1, 1'b1, 1'b0);
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 6; i++) begin
        v = '0; v[0] = pat[i];
        drive(v, '1, '1, 1'b0, 1'b0);
      end
    end
    checks++;
    if (evt_cnt[CW-1:0] !== CW'(3)) begin
      errors++;
      $display("FAIL evt_sat got %0d want 3", evt_cnt[CW-1:0]);
    end
    v = '0; v[0] = 1'b1;
    drive(v, '1, '1, 1'b0, 1'b0);
    drive(v, '1, '1, 1'b0, 1'b0);
    drive(v, '1, '1, 1'b0, 1'b1);
    checks++;
    if (evt_cnt[CW-1:0] !== '0 || out[0] !== 1'b1) begin
      errors++;
      $display("FAIL evt_clr_wins got evt=%0d out=%b want 0/1", evt_cnt[CW-1:0], out[0]);
    end
    settle();
`endif
  endtask

  task automatic test_all_channels();
    logic [CH-1:0] v;
    bit same = 1;
    for (int i = 0; i < 40; i++) begin
      v = {CH{1'($urandom_range(0, 1))}};
      drive(v, '1, '1, 1'b0, 1'b0);
      if (out !== '0 && out !== '1) same = 0;
    end
    checks++;
    if (!same) begin
      errors++;
      $display("FAIL all_ch_identical got differing bits want equal");
    end
    settle();
    for (int k = 0; k < CH1; k++) begin
      int hi = 0, bhi = 0;
      bit stray = 0;
      for (int i = 0; i < 6; i++) begin
        t_in1 = '0;
        if (i == 0) t_in1[k] = 1'b1;
        drive('0, '1, '1, 1'b0, 1'b0);
        if (out1[k]) hi++;
        if (busy1[k]) bhi++;
        if ((out1 & ~(CH1'(1) << k)) != '0) stray = 1;
      end
      checks++;
      if (hi != 3 || bhi != 3 || stray) begin
        errors++;
        $display("FAIL n1_pulse ch %0d got out=%0d busy=%0d stray=%0d want 3/3/0", k, hi, bhi, stray);
      end
    end
    t_in1 = '0;
  endtask

  task automatic test_random();
    logic [CH-1:0] v, p, e;
    p = '1;
    for (int i = 0; i < 300; i++) begin
      v = CH'($urandom);
      if ($urandom_range(0, 19) == 0) p = CH'($urandom);
      e = '1;
      if ($urandom_range(0, 9) == 0) e = CH'($urandom);
      drive(v, p, e, ($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0));
    end
    settle();
  endtask

  initial begin
    t_rst = 1'b1; t_clr = 1'b0; t_in = '0; t_pol = '1; t_en = '1; t_in1 = '0;
    test_reset();
    test_basic();
    test_hold_skip();
    test_polarity();
    test_abort();
    test_evt_cnt();
    test_all_channels();
    test_random();
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fltr_multi_ch.md
FLTR_MULTI_CH -- requirements
Module: fltr_multi_ch

Interface
REQ-001 SHALL have parameter CH, default 4: number of independent filter channels, range 1..32.
REQ-002 SHALL have parameter N, default 3: consecutive active samples required to trigger, range 1..255.
REQ-003 SHALL have parameter PULSE, default 2: output pulse length in clk cycles, range 1..255.
REQ-004 SHALL have parameter CW, default 8: event counter width per channel, range 1..16.
REQ-005 SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port in, input, CH: raw channel inputs, bit k = channel k.
REQ-008 SHALL have port pol, input, CH: active level per channel, 1 = active-high, 0 = active-low.
REQ-009 SHALL have port en, input, CH: per-channel enable.
REQ-010 SHALL have port out, output, CH: registered trigger pulse per channel.
REQ-011 SHALL have port busy, output, CH: registered, high while channel is in PULSE or SKIP.
REQ-012 SHALL have ports clr_cnt (input, 1) and evt_cnt (output, CH*CW, channel k at bits [k*CW +: CW]), present only when FLTR_EVT_CNT_EN is defined.

Function
REQ-013 SHALL derive per channel act = in[k] XNOR pol[k], sampled each clk edge; pol changes take effect on the next sample.
REQ-014 SHALL implement per channel an FSM with states IDLE, PULSE, SKIP and an 8-bit run counter saturating at N.
REQ-015 IDLE: act increments run counter, !act clears it to 0; out = 0.
REQ-016 IDLE -> PULSE on the edge sampling the Nth consecutive active sample; out rises at that edge (visible the following cycle); run counter cleared.
REQ-017 N = 1: any single active sample in IDLE SHALL trigger.
REQ-018 PULSE: out = 1 for exactly PULSE cycles via down-counter, regardless of act.
REQ-019 PULSE exit: on the last pulse cycle, next state SKIP if act sampled at that edge, else IDLE; out falls at that edge.
REQ-020 SKIP: out = 0; stays until an inactive sample, then IDLE with run counter 0; the inactive sample itself SHALL NOT count toward the next run.
REQ-021 Retrigger SHALL require at least one inactive sample plus N new active samples after pulse end.
REQ-022 en[k] = 0 SHALL at the next edge force channel k to IDLE, run counter 0, out 0, busy 0, aborting any pulse in progress; counting resumes on the first sample with en[k] = 1.
REQ-023 Channels SHALL be fully independent; simultaneous triggers on several channels all SHALL be honoured in the same cycle.
REQ-024 busy[k] SHALL be 1 exactly when channel k state is PULSE or SKIP, registered with the state.

Reset
REQ-025 rst = 1 at a clk edge SHALL set all channels to IDLE, run and pulse counters 0, out = 0, busy = 0, evt_cnt = 0.
REQ-026 rst asserted mid-pulse SHALL terminate the pulse at that edge; no partial pulse resumes after release.
REQ-027 First sample counted after reset SHALL be the one at the first edge with rst = 0.

Configuration
REQ-028 Macro FLTR_EVT_CNT_EN defined: per-channel CW-bit counter increments on each IDLE -> PULSE transition, saturates at 2^CW - 1, clr_cnt = 1 clears all counters synchronously, clear wins over a simultaneous event.
REQ-029 Macro FLTR_EVT_CNT_EN undefined: counters, clr_cnt and evt_cnt SHALL be absent; all other behaviour identical.

Verification
REQ-030 N=3, PULSE=2, pol=1, in[0] = 0,1,1,1,0,0: out[0] high exactly cycles 4-5 after the third 1; busy[0] high for those 2 cycles then low.
REQ-031 N=3, PULSE=2, in[1] held 1 for 10 cycles then 0, then 1 for 3 cycles: one pulse in the first run (busy stays high through SKIP), second pulse only after the 0 and 3 new 1s.
REQ-032 pol[2]=0, in[2] = 1,0,0,0,1: pulse triggers on the third 0; in[2] run 1,1,0,1,1,1 with pol=1: pulse only after the final three 1s.
REQ-033 Trigger on channel 3, deassert en[3] on first pulse cycle: out[3] low next cycle, busy[3] low, no SKIP; rst mid-pulse on channel 0: same result, evt_cnt zeroed.
REQ-034 With FLTR_EVT_CNT_EN, CW=2: 5 triggers on channel 0 -> evt_cnt[0] = 3 (saturated); clr_cnt asserted same cycle as a trigger -> evt_cnt[0] = 0.
REQ-035 All CH channels fed identical stimulus: out identical on every bit in every cycle; N=1 single-cycle 1 on each channel: pulse of PULSE cycles each.
